// File: rtl/unit_tx_scheduler_pkg.sv
// Shared types and width helpers for the unit transmit scheduler.
// No logic of its own; latency not applicable.
// No backpressure; constants and functions only.
package unit_tx_scheduler_pkg;

   // Per-unit credit counter width; holds any MAX_OUTSTANDING up to 15.
   localparam int CREDIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_GRANT  = 2'd2
   } state_e;

   // Bits needed to hold value v, i.e. index of its highest set bit plus one (minimum 1).
   function automatic int msb_w(input int v);
      int w;
      w = 1;
      for (int b = 1; b < 31; b++) begin
         if ((v >> b) != 0) w = b + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/unit_tx_scheduler_if.sv
// Handshake bundle between the transmit FSM, the receive side and the scheduler.
// Pure wiring; no latency.
// req is held by the requester until grant_valid or abandoned by dropping it.
interface unit_tx_scheduler_if #(
   parameter int N_UNITS         = 16,
   parameter int MAX_OUTSTANDING = 2
);
   import unit_tx_scheduler_pkg::*;

   localparam int IW = msb_w(N_UNITS - 1);
   localparam int TW = msb_w(N_UNITS * MAX_OUTSTANDING);

   logic                req;
   logic                grant_valid;
   logic [IW-1:0]       grant_num;
   logic [N_UNITS-1:0]  grant_onehot;
   logic                tx_done;
   logic [N_UNITS-1:0]  unit_ready;
   logic [N_UNITS-1:0]  unit_tx_mask;
   logic                rx_done;
   logic [IW-1:0]       rx_num;
   logic [TW-1:0]       total_outstanding;
   logic                idle;
   logic                err;

   // Requester / unit-array side.
   modport master (
      output req, tx_done, unit_ready, unit_tx_mask, rx_done, rx_num,
      input  grant_valid, grant_num, grant_onehot, total_outstanding, idle, err
   );

   // Scheduler side.
   modport slave (
      input  req, tx_done, unit_ready, unit_tx_mask, rx_done, rx_num,
      output grant_valid, grant_num, grant_onehot, total_outstanding, idle, err
   );

endinterface

// File: rtl/unit_credit_counter.sv
// In-flight candidate counter for one unit; saturates at MAX_OUTSTANDING, never below 0.
// Count updates one cycle after inc/dec; at_max and underflow are combinational.
// No backpressure; inc and dec in the same cycle cancel.
module unit_credit_counter
   import unit_tx_scheduler_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                inc,
   input  logic                dec,
   input  logic                clr,
   output logic [CREDIT_W-1:0] count,
   output logic                at_max,
   output logic                underflow
);

   logic [CREDIT_W-1:0] count_q, count_d;

   assign at_max = (count_q >= CREDIT_W'(MAX_OUTSTANDING));
   assign count  = count_q;

   // Next count: clear wins, then a lone inc or dec; a dec at zero is flagged and dropped.
   always_comb begin
      count_d   = count_q;
      underflow = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (inc && !dec) begin
         if (!at_max) count_d = count_q + 1'b1;
      end else if (dec && !inc) begin
         if (count_q == '0) underflow = 1'b1;
         else               count_d   = count_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/unit_tx_scheduler.sv
// Round-robin grant of the shared unit-input bus, skipping masked, not-ready or full units.
// req to grant_valid: 2 cycles minimum, N_UNITS+1 worst case; grant held until tx_done.
// Requester may drop req to abandon; full units are simply skipped, scanning never stops.
module unit_tx_scheduler
   import unit_tx_scheduler_pkg::*;
#(
   parameter int N_UNITS         = 16,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   unit_tx_scheduler_if.slave    bus
);

   localparam int            IW   = msb_w(N_UNITS - 1);
   localparam int            TW   = msb_w(N_UNITS * MAX_OUTSTANDING);
   localparam logic [IW-1:0] LAST = IW'(N_UNITS - 1);
   localparam logic [IW:0]   SCAN_SAT = (IW + 1)'(N_UNITS);

   state_e              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gnum_q, gnum_d;
   logic [IW:0]         scan_cnt_q, scan_cnt_d;
   logic [N_UNITS-1:0]  ready_q, ready_d;
   logic [N_UNITS-1:0]  mask_q, mask_d;
   logic                err_q, err_d;

   logic [N_UNITS-1:0]  elig, at_max, inc, dec, underflow;
   logic [CREDIT_W-1:0] credit [N_UNITS];
   logic [TW-1:0]       total_sum;
   logic                tx_acc, rx_ok;

   // rx_num can only be out of range when N_UNITS is not a power of two.
   if ((1 << IW) > N_UNITS) begin : g_rx_rng
      assign rx_ok = (bus.rx_num < IW'(N_UNITS));
   end else begin : g_rx_full
      assign rx_ok = 1'b1;
   end

   // Readiness and mask are looked at one cycle late, from registered copies.
   assign elig = ready_q & ~mask_q & ~at_max;

   for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
      assign inc[i] = tx_acc & (gnum_q == IW'(i));
      assign dec[i] = bus.rx_done & rx_ok & (bus.rx_num == IW'(i));
      unit_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
         .CLK       (CLK),
         .RST_N     (RST_N),
         .inc       (inc[i]),
         .dec       (dec[i]),
         .clr       (1'b0),
         .count     (credit[i]),
         .at_max    (at_max[i]),
         .underflow (underflow[i])
      );
   end

   // Total outstanding is the sum of the per-unit credits, so it can never drift from them.
   always_comb begin
      total_sum = '0;
      for (int i = 0; i < N_UNITS; i++) total_sum = total_sum + TW'(credit[i]);
   end

   // Scheduler FSM next state, pointer walk and grant capture; tx_done beats a req drop.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnum_d     = gnum_q;
      scan_cnt_d = scan_cnt_q;
      tx_acc     = 1'b0;
      ready_d    = bus.unit_ready;
      mask_d     = bus.unit_tx_mask;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               state_d    = ST_SEARCH;
               scan_cnt_d = '0;
            end
         end
         ST_SEARCH: begin
            if (!bus.req) begin
               state_d = ST_IDLE;
            end else if (elig[ptr_q]) begin
               gnum_d  = ptr_q;
               state_d = ST_GRANT;
            end else begin
               ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
               if (scan_cnt_q != SCAN_SAT) scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         ST_GRANT: begin
            if (bus.tx_done) begin
               tx_acc  = 1'b1;
               ptr_d   = (gnum_q == LAST) ? '0 : gnum_q + 1'b1;
               state_d = ST_IDLE;
            end else if (!bus.req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky error: stray tx_done, out-of-range rx_num, or credit underflow.
   always_comb begin
      err_d = err_q;
      if (bus.tx_done && (state_q != ST_GRANT)) err_d = 1'b1;
      if (bus.rx_done && !rx_ok)                err_d = 1'b1;
      if (|underflow)                           err_d = 1'b1;
   end

   // State registers; reset drops any grant in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         gnum_q     <= '0;
         scan_cnt_q <= '0;
         ready_q    <= '0;
         mask_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnum_q     <= gnum_d;
         scan_cnt_q <= scan_cnt_d;
         ready_q    <= ready_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
      end
   end

   assign bus.grant_valid       = (state_q == ST_GRANT);
   assign bus.grant_num         = gnum_q;
   assign bus.grant_onehot      = (state_q == ST_GRANT) ? (N_UNITS'(1) << gnum_q) : '0;
   assign bus.total_outstanding = total_sum;
   assign bus.idle              = (state_q == ST_IDLE) && (total_sum == '0);
   assign bus.err               = err_q;

endmodule

// File: tb/tb_unit_tx_scheduler.sv
// Directed bench for the unit transmit scheduler with four units, two credits each.
// Grant vectors come from a table; credit and reset corner cases are hand sequences.
// Every wait for a grant is bounded.
module tb_unit_tx_scheduler;

   localparam int N   = 4;
   localparam int MAX = 2;

   logic CLK;
   logic RST_N;
   int   checks;
   int   failures;

   unit_tx_scheduler_if #(.N_UNITS(N), .MAX_OUTSTANDING(MAX)) bus ();

   unit_tx_scheduler #(.N_UNITS(N), .MAX_OUTSTANDING(MAX)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] mask;
      logic [3:0] ready;
      int         num;
      logic [3:0] onehot;
      int         lat;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N            = 1'b0;
      bus.req          = 1'b0;
      bus.tx_done      = 1'b0;
      bus.rx_done      = 1'b0;
      bus.rx_num       = '0;
      bus.unit_ready   = '0;
      bus.unit_tx_mask = '0;
      step();
      step();
      RST_N = 1'b1;
      step();
   endtask

   // Wait for grant_valid, counting rising edges from the first one that samples req.
   task automatic wait_grant(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int k = 1; k <= 20 && !ok; k++) begin
         step();
         if (bus.grant_valid) begin
            lat = k;
            ok  = 1'b1;
         end
      end
   endtask

   task automatic grant_and_done(input string tag, input int exp_num, input int exp_lat);
      int lat;
      bit ok;
      bus.req = 1'b1;
      wait_grant(lat, ok);
      chk({tag, "_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         chk({tag, "_num"}, 32'(bus.grant_num), 32'(exp_num));
         chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      end
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      bus.req     = 1'b0;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      int lat;
      bit ok;
      for (int v = lo; v <= hi; v++) begin
         bus.unit_tx_mask = vt[v].mask;
         bus.unit_ready   = vt[v].ready;
         step();
         bus.req = 1'b1;
         wait_grant(lat, ok);
         chk($sformatf("vec%0d_seen", v), 32'(ok), 32'd1);
         chk($sformatf("vec%0d_num", v), 32'(bus.grant_num), 32'(vt[v].num));
         chk($sformatf("vec%0d_onehot", v), 32'(bus.grant_onehot), 32'(vt[v].onehot));
         chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vt[v].lat));
         bus.tx_done = 1'b1;
         step();
         bus.tx_done = 1'b0;
         bus.req     = 1'b0;
      end
   endtask

   // Hold req for a window and count any grant that shows up.
   task automatic no_grant_window(input string tag);
      int seen;
      seen    = 0;
      bus.req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (bus.grant_valid) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int lat;
      bit ok;
      checks   = 0;
      failures = 0;

      // Round robin over four open units, two rounds.
      for (int i = 0; i < 8; i++) begin
         vt[i].mask   = 4'b0000;
         vt[i].ready  = 4'b1111;
         vt[i].num    = i % 4;
         vt[i].onehot = 4'(1 << (i % 4));
         vt[i].lat    = 2;
      end
      // Units 0 and 2 masked: alternate 1 and 3, each one skip away.
      for (int i = 8; i < 12; i++) begin
         vt[i].mask   = 4'b0101;
         vt[i].ready  = 4'b1111;
         vt[i].num    = (i % 2 == 0) ? 1 : 3;
         vt[i].onehot = (i % 2 == 0) ? 4'b0010 : 4'b1000;
         vt[i].lat    = 3;
      end

      // Reset values.
      do_reset();
      chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
      chk("rst_grant_num", 32'(bus.grant_num), 32'd0);
      chk("rst_grant_onehot", 32'(bus.grant_onehot), 32'd0);
      chk("rst_total", 32'(bus.total_outstanding), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_idle", 32'(bus.idle), 32'd1);

      // Eight back-to-back grants, then every unit is full.
      run_vectors(0, 7);
      no_grant_window("t1_no_grant_when_full");
      chk("t1_total", 32'(bus.total_outstanding), 32'd8);
      chk("t1_idle", 32'(bus.idle), 32'd0);
      bus.req = 1'b0;
      step();
      step();
      // Release everything through the receive side.
      for (int k = 0; k < 8; k++) begin
         bus.rx_done = 1'b1;
         bus.rx_num  = 2'(k % 4);
         step();
      end
      bus.rx_done = 1'b0;
      step();
      chk("drain_total", 32'(bus.total_outstanding), 32'd0);
      chk("drain_idle", 32'(bus.idle), 32'd1);
      chk("drain_err", 32'(bus.err), 32'd0);

      // Masked units.
      do_reset();
      run_vectors(8, 11);
      chk("t2_total", 32'(bus.total_outstanding), 32'd4);

      // Single ready unit: first grant leaves ptr at 3, second scans the whole ring.
      do_reset();
      bus.unit_ready = 4'b0100;
      step();
      grant_and_done("t3_first", 2, 4);
      grant_and_done("t3_wrap", 2, 5);
      chk("t3_total", 32'(bus.total_outstanding), 32'd2);
      no_grant_window("t3_no_grant_full");
      bus.req = 1'b0;
      step();

      // Simultaneous tx_done and rx_done on the same unit.
      do_reset();
      bus.unit_ready = 4'b0010;
      step();
      grant_and_done("t4_first", 1, 3);
      bus.req = 1'b1;
      wait_grant(lat, ok);
      chk("t4_sim_seen", 32'(ok), 32'd1);
      chk("t4_sim_lat", 32'(lat), 32'd5);
      bus.tx_done = 1'b1;
      bus.rx_done = 1'b1;
      bus.rx_num  = 2'd1;
      step();
      bus.tx_done = 1'b0;
      bus.rx_done = 1'b0;
      bus.req     = 1'b0;
      chk("t4_sim_total", 32'(bus.total_outstanding), 32'd1);
      chk("t4_sim_gv_low", 32'(bus.grant_valid), 32'd0);
      // Abandoned grant: no credit change, pointer stays on unit 1.
      bus.req = 1'b1;
      wait_grant(lat, ok);
      chk("t4_abn_seen", 32'(ok), 32'd1);
      chk("t4_abn_lat", 32'(lat), 32'd5);
      bus.req = 1'b0;
      step();
      chk("t4_abn_gv_low", 32'(bus.grant_valid), 32'd0);
      chk("t4_abn_total", 32'(bus.total_outstanding), 32'd1);
      // Unit 1 still has exactly one credit free.
      grant_and_done("t4_last", 1, 2);
      chk("t4_total2", 32'(bus.total_outstanding), 32'd2);
      no_grant_window("t4_unit1_full");
      bus.req = 1'b0;
      step();
      step();

      // Underflow on unit 0.
      chk("t5_err_before", 32'(bus.err), 32'd0);
      bus.rx_done = 1'b1;
      bus.rx_num  = 2'd0;
      step();
      bus.rx_done = 1'b0;
      chk("t5_err_set", 32'(bus.err), 32'd1);
      chk("t5_total_kept", 32'(bus.total_outstanding), 32'd2);
      step();
      step();
      step();
      chk("t5_err_sticky", 32'(bus.err), 32'd1);
      bus.rx_done = 1'b1;
      bus.rx_num  = 2'd1;
      step();
      bus.rx_done = 1'b0;
      chk("t5_rx_total", 32'(bus.total_outstanding), 32'd1);

      // Reset asserted while a grant is held.
      bus.unit_ready = 4'b1111;
      step();
      bus.req = 1'b1;
      wait_grant(lat, ok);
      chk("t6_seen", 32'(ok), 32'd1);
      #2;
      RST_N   = 1'b0;
      bus.req = 1'b0;
      #1;
      chk("t6_async_gv", 32'(bus.grant_valid), 32'd0);
      chk("t6_async_onehot", 32'(bus.grant_onehot), 32'd0);
      chk("t6_async_err", 32'(bus.err), 32'd0);
      chk("t6_async_total", 32'(bus.total_outstanding), 32'd0);
      step();
      RST_N = 1'b1;
      step();
      chk("t6_rel_idle", 32'(bus.idle), 32'd1);
      chk("t6_rel_total", 32'(bus.total_outstanding), 32'd0);
      // Stray tx_done while idle.
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      chk("t6_stray_tx_err", 32'(bus.err), 32'd1);
      chk("t6_stray_tx_total", 32'(bus.total_outstanding), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unit_tx_scheduler.md
Name: unit_tx_scheduler

Overview:
- Selects the computing unit that receives the next candidate packet from the transmit arbiter, so that the broadcast unit-input bus is shared fairly among N_UNITS units.
- Scans units round-robin and skips units that are masked, not ready, or already holding the maximum number of in-flight candidates.
- Tracks per-unit and total outstanding candidates; the receive side releases them.
- Sits between the transmit FSM (requester) and the unit array, in the CORE clock domain.

Parameters:
N_UNITS, 16, number of computing units (2..256).
MAX_OUTSTANDING, 2, maximum candidates in flight per unit (1..15).

Ports:
CLK  in  1  core clock.
RST_N  in  1  asynchronous active-low reset.
req  in  1  transmit FSM requests a unit; held high until grant_valid, or dropped to abandon.
grant_valid  out  1  a unit is granted; held until tx_done.
grant_num  out  `MSB(N_UNITS-1)+1  index of the granted unit; stable while grant_valid is high.
grant_onehot  out  N_UNITS  one-hot form of grant_num; zero when grant_valid is low.
tx_done  in  1  one-cycle pulse: packet to the granted unit is complete.
unit_ready  in  N_UNITS  per-unit input-ready flags.
unit_tx_mask  in  N_UNITS  1 = unit is excluded from scheduling.
rx_done  in  1  one-cycle pulse: one result was retrieved from unit rx_num.
rx_num  in  `MSB(N_UNITS-1)+1  unit index for rx_done.
total_outstanding  out  `MSB(N_UNITS*MAX_OUTSTANDING)+1  sum of all per-unit credits.
idle  out  1  state is IDLE and total_outstanding == 0.
err  out  1  sticky protocol-error flag.

Behaviour:
Reset (RST_N low, asynchronous):
- State IDLE; pointer ptr = 0; all credits = 0.
- Outputs: grant_valid 0, grant_num 0, grant_onehot 0, total_outstanding 0, err 0; idle = 1.

Eligibility:
- elig(i) = unit_ready[i] & ~unit_tx_mask[i] & (credit[i] < MAX_OUTSTANDING).
- Inputs are sampled into registers; elig is evaluated one cycle late, which is acceptable.

FSM:
- IDLE: if req, go to SEARCH with scan_cnt = 0.
- SEARCH: examines unit ptr, one unit per cycle.
  - If elig(ptr): register grant_num = ptr and go to GRANT.
  - Otherwise: ptr = (ptr == N_UNITS-1) ? 0 : ptr+1, scan_cnt++. Scanning continues indefinitely while req is high.
  - scan_cnt saturates at N_UNITS; it is informational only and carries no error.
  - If req drops: return to IDLE; ptr is kept.
- GRANT:
  - grant_valid = 1 and grant_onehot driven.
  - On tx_done:
    - credit[grant_num]++ and total_outstanding++.
    - ptr = grant_num+1, wrapping to 0 at N_UNITS-1.
    - grant_valid deasserts on the next cycle; return to IDLE.
  - If req drops before tx_done: abandon the grant with no credit change, return to IDLE.

Latency:
- Minimum 2 cycles from req to grant_valid (IDLE→SEARCH→GRANT).
- Worst case N_UNITS+1 cycles when a single unit is eligible.

Credits:
- rx_done decrements credit[rx_num] and total_outstanding.
- Simultaneous tx_done and rx_done:
  - Same unit: that credit is unchanged and total is unchanged.
  - Different units: both updates apply; total is unchanged.
- rx_done with credit[rx_num] == 0 is an underflow: set err; the counter stays 0.
- rx_num ≥ N_UNITS: set err; no update.
- tx_done outside GRANT: set err; ignored.
- Credits never exceed MAX_OUTSTANDING: eligibility prevents it.

Reset mid-operation:
- Everything is cleared immediately.
- Any grant in progress is dropped without a credit update.

Decomposition:
- Shared package: MAX_OUTSTANDING width constant, unit-index width function (the `MSB form), FSM state encodings.
- One sub-module, unit_credit_counter: one instance per unit via generate. Inputs inc, dec, clr. Outputs count and at_max. Also flags underflow.

Test Plan:
1. N_UNITS=4, all units ready and unmasked, 8 back-to-back req/tx_done pairs, no rx_done.
   - Grants go 0,1,2,3,0,1,2,3.
   - After that, no unit is eligible, so grant_valid stays 0 while req is held.
   - total_outstanding = 8 and idle = 0.
2. unit_tx_mask = 4'b0101, all units ready, 4 grants.
   - Grants go 1,3,1,3.
   - grant_onehot values are 0010, 1000, 0010, 1000.
3. Only unit 2 ready, ptr = 3, req asserted.
   - grant_num = 2 and grant_valid rises 5 cycles after req.
4. Unit 1 at credit 1; tx_done for unit 1 and rx_done with rx_num = 1 in the same cycle.
   - credit[1] stays 1 and total_outstanding is unchanged.
5. rx_done with rx_num = 0 while credit[0] = 0.
   - err goes to 1 and stays set; credit[0] remains 0.
6. RST_N pulsed low while in GRANT.
   - grant_valid, grant_onehot and err go to 0 asynchronously.
   - Credits clear to 0; idle = 1 on release.
